// File: rtl/mat_unload.sv
// mat_unload: captures a finished ENTRIES x ENTRY_W result matrix and streams it one entry per valid/ready beat.
// Optional feature macro: MAT_UNLOAD_ABORT_EN adds an abort input that drops an in-flight stream.
module mat_unload #(
  parameter  int ENTRIES = 16,
  parameter  int ENTRY_W = 10,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int MAT_W   = ENTRIES * ENTRY_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAT_W-1:0]   mat_in,
  input  logic               out_ready,
`ifdef MAT_UNLOAD_ABORT_EN
  input  logic               abort,
`endif
  output logic               out_valid,
  output logic [ENTRY_W-1:0] out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  state_e                           state_q, state_d;
  logic [ENTRIES-1:0][ENTRY_W-1:0]  cap_q, cap_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [IDX_W-1:0]                 sel;
  logic                             abort_w;
  logic                             xfer;
  logic                             is_last;

`ifdef MAT_UNLOAD_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Entry 0 sits in the MSBs, i.e. in the highest packed element.
  assign sel     = LAST_IDX - idx_q;
  assign is_last = (idx_q == LAST_IDX);
  assign xfer    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cap_d   = mat_in;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // Abort wins over a simultaneous transfer; that beat is discarded.
        if (abort_w) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (xfer) begin
          if (is_last) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them immediately.
  always_comb begin
    out_valid = (state_q == S_SEND);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    out_data  = out_valid ? cap_q[sel] : '0;
    out_idx   = out_valid ? idx_q      : '0;
    out_last  = out_valid & is_last;
  end

endmodule

// File: tb/tb_mat_unload.sv
// tb_mat_unload: table-driven and randomized checks of mat_unload against a queue-free stream model.
module tb_mat_unload;
  localparam int ENTRIES = 16;
  localparam int ENTRY_W = 10;
  localparam int IDX_W   = 4;
  localparam int MAT_W   = ENTRIES * ENTRY_W;

  logic               clk = 0;
  logic               rst = 1;
  logic               start = 0;
  logic [MAT_W-1:0]   mat_in = '0;
  logic               out_ready = 0;
`ifdef MAT_UNLOAD_ABORT_EN
  logic               abort = 0;
`endif
  logic               out_valid;
  logic [ENTRY_W-1:0] out_data;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  mat_unload #(.ENTRIES(ENTRIES), .ENTRY_W(ENTRY_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mat_in(mat_in), .out_ready(out_ready),
`ifdef MAT_UNLOAD_ABORT_EN
    .abort(abort),
`endif
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MAT_W-1:0]   mat;
    int                 pct;
    int                 stall_at;
    int                 stall_len;
    bit                 noise;
    int                 chk_i;
    logic [ENTRY_W-1:0] chk_v;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: entry i is the i-th ENTRY_W-bit field counted from the MSB end.
  function automatic logic [ENTRY_W-1:0] ent(input logic [MAT_W-1:0] m, input int i);
    logic [MAT_W-1:0] s;
    s = m >> ((ENTRIES - 1 - i) * ENTRY_W);
    return s[ENTRY_W-1:0];
  endfunction

  function automatic logic [MAT_W-1:0] mk_seq(input int base);
    logic [MAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < ENTRIES; i++) r = (r << ENTRY_W) | MAT_W'(base + i);
    return r;
  endfunction

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < ENTRIES; i++) r = (r << ENTRY_W) | MAT_W'($urandom_range(1023));
    return r;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, 32'(out_valid), 0);
    chk({nm, "_data"},  32'(out_data), 0);
    chk({nm, "_idx"},   32'(out_idx), 0);
    chk({nm, "_last"},  32'(out_last), 0);
    chk({nm, "_busy"},  32'(busy), 0);
    chk({nm, "_done"},  32'(done), 0);
  endtask

  // One full stream: start pulse, then per-cycle comparison against the model beat counter.
  task automatic run_stream(input vec_t v);
    int sent = 0;
    int stalled = 0;
    int cyc = 0;
    bit rdy;
    bit seen = 0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(out_valid), 0);
    mat_in = v.mat; start = 1; out_ready = 0;
    @(negedge clk);
    start = 0; cyc = 1;
    while (cyc < 400) begin
      if (sent < ENTRIES) begin
        chk("valid", 32'(out_valid), 1);
        chk("data", 32'(out_data), 32'(ent(v.mat, sent)));
        chk("idx", 32'(out_idx), 32'(sent));
        chk("last", 32'(out_last), 32'(sent == ENTRIES - 1));
        chk("busy", 32'(busy), 1);
        chk("done_early", 32'(done), 0);
        if (sent == v.chk_i && !seen) begin
          chk("vec_entry", 32'(out_data), 32'(v.chk_v));
          seen = 1;
        end
        if (sent == v.stall_at && stalled < v.stall_len) begin
          rdy = 0; stalled++;
        end else begin
          rdy = ($urandom_range(99) < v.pct);
        end
        out_ready = rdy;
        if (v.noise) begin
          mat_in = rand_mat();
          start  = 1'($urandom_range(1));
        end
        if (rdy) sent++;
      end else begin
        chk("done", 32'(done), 1);
        chk("valid_in_done", 32'(out_valid), 0);
        chk("busy_done", 32'(busy), 1);
        if (v.pct == 100 && v.stall_len == 0) chk("done_cycle", 32'(cyc), 17);
        if (v.stall_len > 0 && v.pct == 100) chk("done_cycle_stall", 32'(cyc), 32'(17 + v.stall_len));
        start = 0; out_ready = 0;
        @(negedge clk);
        chk("done_width", 32'(done), 0);
        chk("busy_after", 32'(busy), 0);
        chk("valid_after", 32'(out_valid), 0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    errors++;
    $display("FAIL stream_timeout: sent %0d of %0d", sent, ENTRIES);
    start = 0; out_ready = 0;
  endtask

  vec_t vecs[5];
  logic [MAT_W-1:0] m1, m2, edge_m;
  bit found;

  initial begin
    edge_m = rand_mat();
    edge_m[(ENTRIES)*ENTRY_W-1 -: ENTRY_W] = 10'h000;
    edge_m[ENTRY_W-1:0] = 10'b0000011110;
    vecs[0] = '{mk_seq(1), 100, -1, 0, 0, 15, 10'd16};
    vecs[1] = '{mk_seq(1), 100, 5, 3, 0, 5, 10'd6};
    vecs[2] = '{mk_seq(1), 100, -1, 0, 1, 0, 10'd1};
    vecs[3] = '{edge_m, 100, -1, 0, 0, 15, 10'b0000011110};
    vecs[4] = '{edge_m, 60, 0, 2, 0, 0, 10'h000};

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 0;

    foreach (vecs[k]) run_stream(vecs[k]);

    // Random matrices, random backpressure, random start/mat_in noise mid-stream
    for (int n = 0; n < 6; n++) begin
      vec_t r;
      r = '{rand_mat(), int'($urandom_range(100, 30)), -1, 0, 1'($urandom_range(1)), -1, 10'h0};
      run_stream(r);
    end

    // Async reset mid-stream at index 7, then restart with a new matrix
    @(negedge clk);
    mat_in = mk_seq(1); start = 1; out_ready = 1;
    @(negedge clk);
    start = 0;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (out_valid && out_idx == 4'd7) found = 1;
      else @(negedge clk);
    end
    chk("pre_rst_idx7", 32'(found), 1);
    #2 rst = 1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 0; out_ready = 0;
    run_stream('{mk_seq(100), 100, -1, 0, 0, 0, 10'd100});

    // start held high: back-to-back streams with one idle cycle between
    m1 = rand_mat(); m2 = rand_mat();
    @(negedge clk);
    mat_in = m1; start = 1; out_ready = 1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) mat_in = m2;
      if (c <= 16) chk("b2b_data", 32'(out_data), 32'(ent(m1, c - 1)));
      else chk("b2b_done", 32'(done), 1);
    end
    @(negedge clk);
    chk("b2b_gap_busy", 32'(busy), 0);
    chk("b2b_gap_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("b2b_second_valid", 32'(out_valid), 1);
    chk("b2b_second_idx", 32'(out_idx), 0);
    chk("b2b_second_data", 32'(out_data), 32'(ent(m2, 0)));
    start = 0;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    chk("b2b_second_done", 32'(found), 1);
    out_ready = 0;
    @(negedge clk);
    chk("b2b_end_busy", 32'(busy), 0);

`ifdef MAT_UNLOAD_ABORT_EN
    // Abort with a simultaneous transfer at index 9
    @(negedge clk);
    mat_in = mk_seq(1); start = 1; out_ready = 1;
    @(negedge clk);
    start = 0;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (out_valid && out_idx == 4'd9) found = 1;
      else @(negedge clk);
    end
    chk("pre_abort_idx9", 32'(found), 1);
    abort = 1;
    @(negedge clk);
    abort = 0; out_ready = 0;
    chk_all_zero("post_abort");
    @(negedge clk);
    chk("abort_no_done", 32'(done), 0);
    run_stream('{mk_seq(1), 100, -1, 0, 0, 0, 10'd1});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
